// File: rtl/cmp_pkg.sv
// Shared cascade codes and controller state type for the sequential magnitude comparator.
package cmp_pkg;

    localparam logic [2:0] CAS_GT = 3'b100;
    localparam logic [2:0] CAS_EQ = 3'b010;
    localparam logic [2:0] CAS_LT = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nib_cmp4.sv
// One nibble step of the magnitude cascade: a differing nibble overrides the
// incoming cascade code, an equal nibble passes it through untouched.
module nib_cmp4
    import cmp_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] cas,
    output logic [2:0] q
);

    always_comb begin
        q = cas;
        if (a > b) begin
            q = CAS_GT;
        end else if (a < b) begin
            q = CAS_LT;
        end
    end

endmodule

// File: rtl/seq_mag_cmp.sv
// Sequential magnitude comparator: walks the operands one nibble per cycle, LSB first.
// Build option: SEQ_MAG_CMP_SIGNED_EN selects two's-complement comparison.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// RUN   | comparing nibble idx, LSB nibble first
// DONE  | result on q, holding until out_ready
module seq_mag_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       cas_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       q
);

    localparam int NIBS  = WIDTH / 4;
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       cas_q;
    logic [IDX_W-1:0] idx;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [2:0]       step_q;
    logic             last;

    assign last = (idx == LAST_IDX);

    always_comb begin
        a_nib = a_q[{idx, 2'b00} +: 4];
        b_nib = b_q[{idx, 2'b00} +: 4];
`ifdef SEQ_MAG_CMP_SIGNED_EN
        // Flipping the sign bits maps two's-complement order onto unsigned order.
        if (last) begin
            a_nib[3] = ~a_nib[3];
            b_nib[3] = ~b_nib[3];
        end
`endif
    end

    nib_cmp4 u_nib_cmp4 (
        .a   (a_nib),
        .b   (b_nib),
        .cas (cas_q),
        .q   (step_q)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            cas_q <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_q   <= op_a;
                b_q   <= op_b;
                cas_q <= cas_in;
                idx   <= '0;
            end else if (state == RUN) begin
                cas_q <= step_q;
                if (!last) begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign q         = out_valid ? cas_q : 3'b000;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Bench for seq_mag_cmp (WIDTH=16): vector table through a scoreboard queue,
// plus hand sequences for backpressure and mid-RUN reset.
module tb_seq_mag_cmp;

    localparam int WIDTH = 16;
    localparam int NIBS  = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic [2:0]       cas_in = 3'b000;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2:0]       q;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  cas;
        logic [2:0]  exp;
        int          hold;
    } vec_t;

    vec_t        vecs[$];
    logic [2:0]  exp_q[$];

    seq_mag_cmp #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cas_in    (cas_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word reference, independent of the nibble walk.
    function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] cas);
        if (a == b) return cas;
`ifdef SEQ_MAG_CMP_SIGNED_EN
        return ($signed(a) > $signed(b)) ? 3'b100 : 3'b001;
`else
        return (a > b) ? 3'b100 : 3'b001;
`endif
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic [2:0] cas, input logic [2:0] exp, input int hold);
        vec_t v;
        v.a = a; v.b = b; v.cas = cas; v.exp = exp; v.hold = hold;
        return v;
    endfunction

    // Called and returns at a negedge. Accepts on the next posedge.
    task automatic do_op(input vec_t v);
        int         n;
        logic [2:0] got;
        logic [2:0] exp;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        op_a = v.a; op_b = v.b; cas_in = v.cas; in_valid = 1'b1;
        exp_q.push_back(v.exp);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs: the operation in progress must ignore them.
        in_valid = 1'b0;
        op_a = ~v.a; op_b = 16'($urandom); cas_in = ~v.cas;
        n = 1;
        while (!out_valid && n < 40) begin
            check("in_ready_run", 32'(in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check("timeout_out_valid", 32'(out_valid), 32'd1);
            void'(exp_q.pop_front());
            return;
        end
        check("latency", 32'(n), 32'(NIBS + 1));
        got = q;
        exp = exp_q.pop_front();
        check("q_result", 32'(got), 32'(exp));
        for (int i = 0; i < v.hold; i++) begin
            in_valid = 1'(i[0] ^ 1'b1);
            op_a = 16'($urandom); op_b = 16'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_q", 32'(q), 32'(got));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        // Release with in_valid high: must not accept on the same edge.
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_q", 32'(q), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  rc;
        vec_t        v;

        vecs.push_back(mk(16'h1234, 16'h1234, 3'b010, 3'b010, 0));
`ifdef SEQ_MAG_CMP_SIGNED_EN
        vecs.push_back(mk(16'h8000, 16'h7FFF, 3'b010, 3'b001, 0));
        vecs.push_back(mk(16'h7FFF, 16'h8000, 3'b010, 3'b100, 0));
        vecs.push_back(mk(16'hFFFF, 16'h0000, 3'b001, 3'b001, 0));
`else
        vecs.push_back(mk(16'h8000, 16'h7FFF, 3'b010, 3'b100, 0));
        vecs.push_back(mk(16'h7FFF, 16'h8000, 3'b010, 3'b001, 0));
        vecs.push_back(mk(16'hFFFF, 16'h0000, 3'b001, 3'b100, 0));
`endif
        vecs.push_back(mk(16'h00F1, 16'h00F2, 3'b100, 3'b001, 0));
        vecs.push_back(mk(16'hABCD, 16'hABCD, 3'b011, 3'b011, 0));
        vecs.push_back(mk(16'h0000, 16'h0000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(16'h5555, 16'h5555, 3'b110, 3'b110, 0));
        vecs.push_back(mk(16'h9999, 16'h9999, 3'b111, 3'b111, 0));
        vecs.push_back(mk(16'h2000, 16'h1FFF, 3'b001, 3'b100, 3));
        vecs.push_back(mk(16'h1230, 16'h1231, 3'b100, 3'b001, 0));
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = (i < 2) ? ra : 16'($urandom);
            rc = 3'($urandom);
            vecs.push_back(mk(ra, rb, rc, ref_cmp(ra, rb, rc), i % 2));
        end

        // Reset state, checked while rst_n is still low.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First operation is presented for the very first edge after reset release.
        foreach (vecs[k]) begin
            do_op(vecs[k]);
        end

        // Mid-RUN reset: two edges into RUN, then pulse rst_n.
        op_a = 16'h4321; op_b = 16'h1234; cas_in = 3'b010; in_valid = 1'b1;
        exp_q.push_back(3'b100);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("run2_state", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_q", 32'(q), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        v = mk(16'h00FF, 16'h0F00, 3'b100, 3'b001, 1);
        do_op(v);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
